// File: rtl/fetch_unit.sv
// Instruction fetch: PC generation, credit-limited imem requests, in-flight PC
// tracking and a small registered instruction buffer feeding decode.
module fetch_unit #(
    parameter int               XLEN       = 32,
    parameter logic [XLEN-1:0]  RESET_PC   = '0,
    parameter int               FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    logic [XLEN-1:0] pc;
    logic [CW-1:0]   outstanding, drop_cnt, fifo_count;
    logic [PW-1:0]   fifo_wr, fifo_rd, infl_wr, infl_rd;
    fetch_entry_t    fifo_mem [FIFO_DEPTH];
    logic [XLEN-1:0] infl_mem [FIFO_DEPTH];
    logic [CW:0]     credits_used;
    logic            req_fire, resp_keep, pop;

    // Buffered plus in-flight never exceeds depth, so every kept response has a slot.
    assign credits_used   = {1'b0, fifo_count} + {1'b0, outstanding};
    assign imem_req_valid = rst_n && !redirect_valid && (credits_used < DEPTH_C);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign resp_keep      = imem_resp_valid && !redirect_valid && (drop_cnt == '0);

    assign id_valid = (fifo_count != '0);
    assign pop      = id_valid && id_ready;
    assign id_instr = id_valid ? fifo_mem[fifo_rd].instr : '0;
    assign id_pc    = id_valid ? fifo_mem[fifo_rd].pc    : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);
            if (redirect_valid) begin
                pc       <= {redirect_pc[XLEN-1:2], 2'b00};
                // A response landing in the redirect cycle is discarded here, not counted.
                drop_cnt <= outstanding - CW'(imem_resp_valid);
            end else begin
                if (req_fire)
                    pc <= pc + XLEN'(4);
                if (imem_resp_valid && drop_cnt != '0)
                    drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_wr    <= '0;
            fifo_rd    <= '0;
            fifo_count <= '0;
            infl_wr    <= '0;
            infl_rd    <= '0;
        end else if (redirect_valid) begin
            fifo_wr    <= '0;
            fifo_rd    <= '0;
            fifo_count <= '0;
            infl_wr    <= '0;
            infl_rd    <= '0;
        end else begin
            if (req_fire)  infl_wr <= infl_wr + PW'(1);
            if (resp_keep) infl_rd <= infl_rd + PW'(1);
            if (resp_keep) fifo_wr <= fifo_wr + PW'(1);
            if (pop)       fifo_rd <= fifo_rd + PW'(1);
            fifo_count <= fifo_count + CW'(resp_keep) - CW'(pop);
        end
    end

    // Storage needs no reset: contents are only visible behind the counters.
    always_ff @(posedge clk) begin
        if (req_fire)
            infl_mem[infl_wr] <= pc;
        if (resp_keep)
            fifo_mem[fifo_wr] <= '{instr: imem_resp_data, pc: infl_mem[infl_rd]};
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: random memory latency/backpressure, redirects,
// decode stalls and mid-stream resets, checked against a queue-based model.
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid, id_ready;
    logic [31:0] id_instr, id_pc;

    fetch_unit #(.XLEN(32), .RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc(id_pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] data; int due; } mem_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;

    mem_t        mem_q[$];
    ent_t        fq[$];
    logic [31:0] inflq[$];
    logic [31:0] m_pc;
    int          m_out, m_drop;
    int          n_pass = 0, n_chk = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_out = 0; m_drop = 0;
        fq.delete(); inflq.delete(); mem_q.delete();
    endtask

    task automatic check_reset_outputs();
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_req_addr",  imem_req_addr, RST_PC);
        chk("rst_id_valid",  {31'b0, id_valid}, 32'd0);
        chk("rst_id_instr",  id_instr, 32'd0);
        chk("rst_id_pc",     id_pc, 32'd0);
    endtask

    initial begin
        int          cyc;
        logic        exp_rv, fire, resp, popd, dut_fire;
        logic [31:0] r;

        rst_n = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
        imem_resp_data = '0; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_reset_outputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc = 0;

        for (int it = 0; it < 4000; it++) begin
            @(posedge clk);
            #1;
            if (it > 20 && $urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                #1 check_reset_outputs();
                model_reset();
                @(posedge clk);
                #1 rst_n = 1'b1;
            end

            // Early phase: full-speed memory and decode to see the address wrap cleanly.
            imem_req_ready = (it < 12) ? 1'b1 : ($urandom_range(0, 3) != 0);
            id_ready       = (it < 12) ? 1'b1 : ($urandom_range(0, 3) != 0);
            redirect_valid = (it > 12) && ($urandom_range(0, 15) == 0);
            r = $urandom();
            if ($urandom_range(0, 3) == 0) r = 32'hFFFF_FFF0 | (r & 32'hF);
            redirect_pc = r;
            if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_q[0].data;
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = $urandom();
            end
            #1;

            exp_rv = !redirect_valid && (fq.size() + m_out < DEPTH);
            chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
            chk("req_addr",  imem_req_addr, m_pc);
            chk("id_valid",  {31'b0, id_valid}, {31'b0, fq.size() > 0});
            if (fq.size() > 0) begin
                chk("id_instr", id_instr, fq[0].instr);
                chk("id_pc",    id_pc,    fq[0].pc);
            end

            // Memory environment follows the DUT's actual handshake.
            dut_fire = imem_req_valid && imem_req_ready;
            if (imem_resp_valid) void'(mem_q.pop_front());
            if (dut_fire) mem_q.push_back('{data: $urandom(), due: cyc + $urandom_range(1, 4)});

            fire = exp_rv && imem_req_ready;
            resp = imem_resp_valid;
            popd = (fq.size() > 0) && id_ready;
            if (popd) void'(fq.pop_front());
            if (redirect_valid) begin
                m_drop = m_out - (resp ? 1 : 0);
                m_out  = m_drop;
                m_pc   = redirect_pc & 32'hFFFF_FFFC;
                fq.delete();
                inflq.delete();
            end else begin
                if (resp) begin
                    m_out--;
                    if (m_drop > 0) m_drop--;
                    else if (inflq.size() > 0) fq.push_back('{instr: imem_resp_data, pc: inflq.pop_front()});
                end
                if (fire) begin
                    inflq.push_back(m_pc);
                    m_pc = m_pc + 32'd4;
                    m_out++;
                end
            end
            cyc++;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
